// File: rtl/spi_mem_slave.sv
// spi_mem_slave: SPI slave front end for the single-port memory subsystem.
// Deserialises MOSI frames (2-bit command followed by an address or data
// payload) into memory write/read strobes and serialises read data onto MISO.
// All outputs are registered. dbg_state exposes the FSM state for observation.
//
// Build option: define SPI_BURST_EN to enable auto-incrementing burst
// transfers within one ss_n assertion. When it is undefined, each write-data or
// read-data frame moves exactly one word and addresses never auto-increment.
//
// Handshake: mem_we and mem_re are single-cycle strobes with mem_addr (and
// mem_wdata) valid in the same cycle; the memory answers a read by pulsing
// mem_rvalid with mem_rdata at least one cycle after mem_re. A mem_rvalid
// arriving in any state other than RD_WAIT is ignored.
module spi_mem_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic [3:0]            dbg_state
);

    // Shift register wide enough for either an address or a data payload.
    localparam int SHW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam logic [5:0] ADDR_LAST = 6'(ADDR_WIDTH - 1);
    localparam logic [5:0] DATA_LAST = 6'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_TX,
        S_DRAIN
    } state_t;

    state_t                state_q,     state_d;
    logic                  cmd_hi_q,    cmd_hi_d;
    logic [5:0]            cnt_q,       cnt_d;
    logic [SHW-1:0]        rx_q,        rx_d;
    logic [DATA_WIDTH-1:0] tx_q,        tx_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q,    mem_we_d;
    logic                  mem_re_q,    mem_re_d;
    logic                  miso_q,      miso_d;
    logic [SHW-1:0]        rx_next;

    assign rx_next = {rx_q[SHW-2:0], MOSI};

    // Next-state and registered-output computation; ss_n high overrides everything.
    always_comb begin
        state_d     = state_q;
        cmd_hi_d    = cmd_hi_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        miso_d      = 1'b0;

        if (ss_n) begin
            // Frame ended: drop any partial word or pending read.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cmd_hi_d = MOSI;
                    state_d  = S_CMD;
                end
                S_CMD: begin
                    cnt_d = '0;
                    rx_d  = '0;
                    unique case ({cmd_hi_q, MOSI})
                        2'b00: state_d = S_WR_ADDR;
                        2'b01: state_d = S_WR_DATA;
                        2'b10: state_d = S_RD_ADDR;
                        2'b11: begin
                            state_d    = S_RD_REQ;
                            mem_re_d   = 1'b1;
                            mem_addr_d = rd_addr_q;
                        end
                    endcase
                end
                S_WR_ADDR: begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == ADDR_LAST) begin
                        wr_addr_d = rx_next[ADDR_WIDTH-1:0];
                        state_d   = S_DRAIN;
                    end
                end
                S_RD_ADDR: begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == ADDR_LAST) begin
                        rd_addr_d = rx_next[ADDR_WIDTH-1:0];
                        state_d   = S_DRAIN;
                    end
                end
                S_WR_DATA: begin
                    rx_d = rx_next;
                    if (cnt_q == DATA_LAST) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = wr_addr_q;
                        mem_wdata_d = rx_next[DATA_WIDTH-1:0];
                        cnt_d       = '0;
`ifdef SPI_BURST_EN
                        wr_addr_d   = wr_addr_q + ADDR_ONE;
`else
                        state_d     = S_DRAIN;
`endif
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_RD_REQ: begin
                    // mem_re was raised on entry; just wait for the answer.
                    state_d = S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (mem_rvalid) begin
                        miso_d  = mem_rdata[DATA_WIDTH-1];
                        tx_d    = mem_rdata << 1;
                        cnt_d   = '0;
                        state_d = S_RD_TX;
                    end
                end
                S_RD_TX: begin
                    if (cnt_q == DATA_LAST) begin
`ifdef SPI_BURST_EN
                        rd_addr_d  = rd_addr_q + ADDR_ONE;
                        mem_re_d   = 1'b1;
                        mem_addr_d = rd_addr_q + ADDR_ONE;
                        state_d    = S_RD_REQ;
`else
                        state_d    = S_DRAIN;
`endif
                    end else begin
                        miso_d = tx_q[DATA_WIDTH-1];
                        tx_d   = tx_q << 1;
                        cnt_d  = cnt_q + 6'd1;
                    end
                end
                S_DRAIN: begin
                    state_d = S_DRAIN;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_hi_q    <= 1'b0;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_hi_q    <= cmd_hi_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            miso_q      <= miso_d;
        end
    end

    assign MISO      = miso_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// tb_spi_mem_slave: randomized scoreboard bench for spi_mem_slave.
// Drivers issue SPI frames and push expected strobes / read words computed from
// a frame-level reference model; a monitor pops and compares on each strobe
// and checks MISO every cycle. Honours SPI_BURST_EN like the design.
`timescale 1ns/1ps
module tb_spi_mem_slave;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic          ss_n;
    logic          MOSI;
    logic          MISO;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic [3:0]    dbg_state;

    spi_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ss_n       (ss_n),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW+DW-1:0] exp_we_q[$];
    logic [AW-1:0]    exp_re_q[$];
    logic [DW-1:0]    exp_rd_q[$];

    // Reference model state (frame level).
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_wr_addr;
    int            ref_rd_addr;
    bit            rd_known;

    // Environment memory, updated only by the DUT's write strobes.
    logic [DW-1:0] sim_mem [DEPTH];
    int            mem_lat;

    logic [DW-1:0] words [4];
    int            rd_words_done = 0;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Memory model: answers mem_re after mem_lat cycles (0 = random 1..3).
    initial begin
        int            rv_cnt;
        logic [DW-1:0] rv_data;
        rv_cnt     = 0;
        rv_data    = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rv_data;
                end
            end
            if (mem_we) sim_mem[mem_addr] = mem_wdata;
            if (mem_re) begin
                rv_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
                rv_data = sim_mem[mem_addr];
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit            rd_pending;
        int            tx_cnt;
        logic [DW-1:0] tx_word;
        logic [AW+DW-1:0] e;
        rd_pending = 1'b0;
        tx_cnt     = 0;
        tx_word    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_miso",      64'(MISO),      64'd0);
                check("rst_mem_we",    64'(mem_we),    64'd0);
                check("rst_mem_re",    64'(mem_re),    64'd0);
                check("rst_mem_addr",  64'(mem_addr),  64'd0);
                check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
                rd_pending = 1'b0;
                tx_cnt     = 0;
            end else begin
                if (tx_cnt > 0) begin
                    check("miso_bit", 64'(MISO), 64'(tx_word[tx_cnt-1]));
                    tx_cnt--;
                    if (tx_cnt == 0) rd_words_done++;
                end else begin
                    check("miso_idle", 64'(MISO), 64'd0);
                end
                if (mem_rvalid && rd_pending) begin
                    rd_pending = 1'b0;
                    if (exp_rd_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL rd_word: read answered with no expected word at %0t", $time);
                    end else begin
                        tx_word = exp_rd_q.pop_front();
                        tx_cnt  = DW;
                    end
                end
                if (mem_we && mem_re) begin
                    n_checks++;
                    $display("FAIL we_re_overlap: mem_we=1 mem_re=1 at %0t", $time);
                end
                if (mem_we) begin
                    if (exp_we_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_we: addr 0x%0h data 0x%0h, none expected at %0t",
                                 mem_addr, mem_wdata, $time);
                    end else begin
                        e = exp_we_q.pop_front();
                        check("we_addr", 64'(mem_addr),  64'(e[AW+DW-1:DW]));
                        check("we_data", 64'(mem_wdata), 64'(e[DW-1:0]));
                    end
                end
                if (mem_re) begin
                    if (exp_re_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_re: addr 0x%0h, none expected at %0t", mem_addr, $time);
                    end else begin
                        check("re_addr", 64'(mem_addr), 64'(exp_re_q.pop_front()));
                    end
                    rd_pending = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b);
        ss_n = 1'b0;
        MOSI = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ss_n = 1'b1;
        repeat (n) begin
            MOSI = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_addr_frame(input int a);
        logic [AW-1:0] av;
        av = AW'(a);
        send_bit(1'b0);
        send_bit(1'b0);
        for (int i = AW - 1; i >= 0; i--) send_bit(av[i]);
        ref_wr_addr = a % DEPTH;
        idle(2);
    endtask

    task automatic read_addr_frame(input int a);
        logic [AW-1:0] av;
        av = AW'(a);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = AW - 1; i >= 0; i--) send_bit(av[i]);
        ref_rd_addr = a % DEPTH;
        rd_known    = 1'b1;
        idle(2);
    endtask

    task automatic write_data_frame(input int n);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int w = 0; w < n; w++) begin
            logic [DW-1:0] wv;
            wv = words[w];
`ifdef SPI_BURST_EN
            exp_we_q.push_back({AW'(ref_wr_addr), wv});
            ref_mem[ref_wr_addr] = wv;
            ref_wr_addr = (ref_wr_addr + 1) % DEPTH;
`else
            if (w == 0) begin
                exp_we_q.push_back({AW'(ref_wr_addr), wv});
                ref_mem[ref_wr_addr] = wv;
            end
`endif
            for (int i = DW - 1; i >= 0; i--) send_bit(wv[i]);
        end
        idle(2);
    endtask

    // Write-data frame abandoned after k (< DW) bits: nothing is written.
    task automatic partial_write_frame(input int k);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < k; i++) send_bit(1'($urandom));
        idle(2);
    endtask

    task automatic read_data_frame(input int n);
        int target;
`ifndef SPI_BURST_EN
        n = 1;
`endif
        for (int i = 0; i < n; i++) begin
            int a;
            a = (ref_rd_addr + i) % DEPTH;
            exp_re_q.push_back(AW'(a));
            exp_rd_q.push_back(ref_mem[a]);
        end
        target = rd_words_done + n;
        send_bit(1'b1);
        send_bit(1'b1);
        // Keep ss_n low until the last bit is on MISO, then release it
        // before the following edge.
        for (int c = 0; c < 60 * n && rd_words_done < target; c++) begin
            @(negedge clk);
            #1;
            MOSI = 1'($urandom);
        end
        if (rd_words_done < target) begin
            n_checks++;
            $display("FAIL read_timeout: words done %0d expected %0d", rd_words_done, target);
        end
`ifdef SPI_BURST_EN
        rd_known = 1'b0;
`endif
        idle(2);
    endtask

    // Read-data frame interrupted by reset while waiting for the memory.
    task automatic reset_during_wait();
        mem_lat = 3;
        exp_re_q.push_back(AW'(ref_rd_addr));
        send_bit(1'b1);
        send_bit(1'b1);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        ss_n = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ref_wr_addr = 0;
        ref_rd_addr = 0;
        rd_known    = 1'b1;
        idle(8);
        mem_lat = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        ss_n        = 1'b1;
        MOSI        = 1'b0;
        mem_lat     = 1;
        ref_wr_addr = 0;
        ref_rd_addr = 0;
        rd_known    = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = DW'($urandom);
            sim_mem[i] = ref_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Single write then read back 0xA5 at 0xF0.
        write_addr_frame(8'hF0);
        words[0] = 8'hA5;
        write_data_frame(1);
        read_addr_frame(8'hF0);
        read_data_frame(1);

        // Three-word write at 0xFF (wraps to 0x00, 0x01 in burst builds).
        write_addr_frame(8'hFF);
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        write_data_frame(3);

        // Abandoned write after 5 bits, then 0x3C lands at the same address.
        write_addr_frame(8'h3A);
        partial_write_frame(5);
        words[0] = 8'h3C;
        write_data_frame(1);
        read_addr_frame(8'h3A);
        read_data_frame(1);

        // Reset while waiting for read data; afterwards rd_addr is 0.
        read_addr_frame(8'h40);
        reset_during_wait();
        read_data_frame(1);

        // Two-word payload (single write unless bursting), then another word.
        write_addr_frame(8'h81);
        words[0] = 8'h5A;
        words[1] = 8'hC3;
        write_data_frame(2);
        words[0] = 8'h77;
        write_data_frame(1);
        read_addr_frame(8'h81);
        read_data_frame(2);

        // Randomized frames with random memory latency.
        mem_lat = 0;
        for (int op = 0; op < 80; op++) begin
            int kind;
            kind = $urandom_range(0, 5);
            case (kind)
                0: write_addr_frame($urandom_range(0, DEPTH - 1));
                1, 2: begin
                    int n;
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) words[i] = DW'($urandom);
                    write_data_frame(n);
                end
                3: read_addr_frame($urandom_range(0, DEPTH - 1));
                4: begin
                    if (!rd_known) read_addr_frame($urandom_range(0, DEPTH - 1));
                    read_data_frame($urandom_range(1, 3));
                end
                default: partial_write_frame($urandom_range(1, DW - 1));
            endcase
            idle($urandom_range(0, 3));
        end

        idle(10);
        check("we_queue_empty", 64'(exp_we_q.size()), 64'd0);
        check("re_queue_empty", 64'(exp_re_q.size()), 64'd0);
        check("rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
